// File: rtl/cgra_isa_pkg.sv
// Shared ISA encodings, issue classes and helpers for the CGRA vector decode/issue path.
package cgra_isa_pkg;

  localparam logic [6:0] OpcVec     = 7'h57;
  localparam logic [6:0] OpcVle     = 7'h07;
  localparam logic [6:0] OpcVse     = 7'h27;
  localparam logic [6:0] OpcVstream = 7'h7F;
  localparam logic [6:0] OpcBranch  = 7'h63;
  localparam logic [6:0] OpcOpImm   = 7'h13;
  localparam logic [6:0] OpcLui     = 7'h37;
  localparam logic [6:0] OpcOp      = 7'h33;
  localparam logic [6:0] OpcCsr     = 7'h03;

  localparam logic [2:0] F3Vmacc    = 3'd0;
  localparam logic [2:0] F3VmvVi    = 3'd5;
  localparam logic [2:0] F3Vsetivli = 3'd7;
  localparam logic [2:0] F3Bne      = 3'd1;
  localparam logic [2:0] F3Addi     = 3'd0;
  localparam logic [2:0] F3Add      = 3'd0;
  localparam logic [6:0] F7Add      = 7'h00;
  localparam logic [11:0] CsrSel    = 12'hC00;

  typedef enum logic [3:0] {
    ClsVle32      = 4'd0,
    ClsVse32      = 4'd1,
    ClsVmacc      = 4'd2,
    ClsVmvVi      = 4'd3,
    ClsVstreamout = 4'd4,
    ClsBne        = 4'd5,
    ClsAddi       = 4'd6,
    ClsLui        = 4'd7,
    ClsAdd        = 4'd8,
    ClsCsr        = 4'd9,
    ClsIllegal    = 4'd15
  } isa_class_e;

  localparam logic [2:0] OpVmacc = 3'b011;
  localparam logic [2:0] OpNop   = 3'b100;

  localparam logic [2:0] OpsLui   = 3'b000;
  localparam logic [2:0] OpsAddi  = 3'b001;
  localparam logic [2:0] OpsBne   = 3'b010;
  localparam logic [2:0] OpsAdd   = 3'b011;
  localparam logic [2:0] OpsOther = 3'b100;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  function automatic logic is_vec_class(input isa_class_e c);
    return (c == ClsVle32) || (c == ClsVse32) || (c == ClsVmacc) ||
           (c == ClsVmvVi) || (c == ClsVstreamout);
  endfunction

  // Register-number bits kept for a given VLEN code: min(vlen+1, 5).
  function automatic logic [4:0] vreg_mask(input logic [2:0] vlen);
    case (vlen)
      3'd0:    return 5'h01;
      3'd1:    return 5'h03;
      3'd2:    return 5'h07;
      3'd3:    return 5'h0F;
      default: return 5'h1F;
    endcase
  endfunction

endpackage

// File: rtl/vec_addr_gen.sv
// Vector-RF address: register number scaled into the VLEN-sized bank, plus element index.
module vec_addr_gen
  import cgra_isa_pkg::*;
#(
  parameter int unsigned DWIDTH_RFADD = 12,
  parameter int unsigned ITR_W        = 12
) (
  input  logic [4:0]              vreg,
  input  logic [2:0]              vlen,
  input  logic [ITR_W-1:0]        idx,
  output logic [DWIDTH_RFADD-1:0] addr
);

  logic [DWIDTH_RFADD-1:0] reg_ext;
  logic [DWIDTH_RFADD-1:0] base;

  assign reg_ext = DWIDTH_RFADD'(vreg & vreg_mask(vlen));
  assign base    = reg_ext << (DWIDTH_RFADD - 32'd1 - 32'(vlen));
  assign addr    = base + DWIDTH_RFADD'(idx);

endmodule

// File: rtl/vec_decode_issue.sv
// Registered scalar/vector decoder for the CGRA control path; vsetivli is absorbed into local
// config and vector instructions expand into one issue beat per element.
module vec_decode_issue
  import cgra_isa_pkg::*;
#(
  parameter int unsigned DWIDTH_INST  = 32,
  parameter int unsigned DWIDTH_RFADD = 12,
  parameter int unsigned DWIDTH_INT   = 32,
  parameter int unsigned ITR_W        = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DWIDTH_INST-1:0]  in_instr,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [3:0]              out_class,
  output logic [2:0]              out_op,
  output logic [2:0]              out_op_scalar,
  output logic [4:0]              out_rs1,
  output logic [4:0]              out_rs2,
  output logic [4:0]              out_rd,
  output logic [DWIDTH_INT-1:0]   out_imm,
  output logic [11:0]             out_branch_imm,
  output logic                    out_wen_rf_scalar,
  output logic [DWIDTH_RFADD-1:0] out_vr_addr,
  output logic [DWIDTH_RFADD-1:0] out_vw_addr,
  output logic [ITR_W-1:0]        out_elem_idx,
  output logic                    out_mux2_tvalid,
  output logic [2:0]              cfg_vlen,
  output logic [ITR_W-1:0]        cfg_itr,
  output logic                    busy
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  isa_class_e dec_class;
  logic       dec_vset;

  always_comb begin
    dec_class = ClsIllegal;
    dec_vset  = 1'b0;
    case (opcode)
      OpcVec: begin
        if (funct3 == F3Vmacc)         dec_class = ClsVmacc;
        else if (funct3 == F3VmvVi)    dec_class = ClsVmvVi;
        else if (funct3 == F3Vsetivli) dec_vset  = 1'b1;
      end
      OpcVle:     dec_class = ClsVle32;
      OpcVse:     dec_class = ClsVse32;
      OpcVstream: dec_class = ClsVstreamout;
      OpcBranch:  if (funct3 == F3Bne) dec_class = ClsBne;
      OpcOpImm:   if (funct3 == F3Addi) dec_class = ClsAddi;
      OpcLui:     dec_class = ClsLui;
      OpcOp:      if (funct3 == F3Add && funct7 == F7Add) dec_class = ClsAdd;
      OpcCsr:     if (in_instr[31:20] == CsrSel) dec_class = ClsCsr;
      default: ;
    endcase
  end

  logic                  dec_vec;
  logic [DWIDTH_INT-1:0] dec_imm;
  logic [2:0]            dec_ops;

  assign dec_vec = is_vec_class(dec_class);

  always_comb begin
    dec_imm = '0;
    dec_ops = OpsOther;
    case (dec_class)
      ClsAddi: begin
        dec_imm = DWIDTH_INT'($signed(in_instr[31:20]));
        dec_ops = OpsAddi;
      end
      ClsLui: begin
        dec_imm = DWIDTH_INT'({in_instr[31:12], 12'h000});
        dec_ops = OpsLui;
      end
      ClsBne:  dec_ops = OpsBne;
      ClsAdd:  dec_ops = OpsAdd;
      default: ;
    endcase
  end

  state_e                  state_q;
  isa_class_e              class_q;
  logic [2:0]              op_q, ops_q, vlen_lat_q, cfg_vlen_q;
  logic [4:0]              rs1_q, rs2_q, rd_q, vr_reg_q, vw_reg_q;
  logic [DWIDTH_INT-1:0]   imm_q;
  logic [11:0]             bimm_q;
  logic                    wen_q, mux2_q, last_q;
  logic [ITR_W-1:0]        idx_q, beats_q, cfg_itr_q;

  logic accept, fire;
  assign out_valid = (state_q == StIssue);
  assign in_ready  = !out_valid || (out_ready && last_q);
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      class_q    <= ClsVle32;  // encoding 0: all data outputs read zero out of reset
      op_q       <= '0;
      ops_q      <= '0;
      vlen_lat_q <= '0;
      cfg_vlen_q <= '0;
      cfg_itr_q  <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      vr_reg_q   <= '0;
      vw_reg_q   <= '0;
      imm_q      <= '0;
      bimm_q     <= '0;
      wen_q      <= 1'b0;
      mux2_q     <= 1'b0;
      last_q     <= 1'b0;
      idx_q      <= '0;
      beats_q    <= '0;
    end else begin
      if (accept && dec_vset) begin
        cfg_vlen_q <= in_instr[17:15];
        cfg_itr_q  <= in_instr[18+ITR_W-1:18];
      end
      if (accept && !dec_vset) begin
        state_q    <= StIssue;
        class_q    <= dec_class;
        op_q       <= (dec_class == ClsVmacc) ? OpVmacc : OpNop;
        ops_q      <= dec_ops;
        rs1_q      <= in_instr[19:15];
        rs2_q      <= in_instr[24:20];
        rd_q       <= in_instr[11:7];
        imm_q      <= dec_imm;
        bimm_q     <= {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]};
        wen_q      <= (dec_class == ClsAddi) || (dec_class == ClsLui) ||
                      (dec_class == ClsAdd) || (dec_class == ClsCsr);
        mux2_q     <= (dec_class == ClsVmacc) || (dec_class == ClsVstreamout);
        vr_reg_q   <= (dec_class == ClsVse32) ? in_instr[11:7] : in_instr[24:20];
        vw_reg_q   <= in_instr[11:7];
        vlen_lat_q <= cfg_vlen_q;
        idx_q      <= '0;
        beats_q    <= (dec_vec && cfg_itr_q != '0) ? cfg_itr_q : ITR_W'(1);
        last_q     <= !(dec_vec && cfg_itr_q > ITR_W'(1));
      end else if (fire) begin
        // A vsetivli accepted alongside the final beat also lands here and closes the burst.
        if (last_q) begin
          state_q <= StIdle;
          last_q  <= 1'b0;
          idx_q   <= '0;
        end else begin
          idx_q  <= idx_q + ITR_W'(1);
          last_q <= (idx_q + ITR_W'(1)) == (beats_q - ITR_W'(1));
        end
      end
    end
  end

  vec_addr_gen #(
    .DWIDTH_RFADD (DWIDTH_RFADD),
    .ITR_W        (ITR_W)
  ) u_vr_addr (
    .vreg (vr_reg_q),
    .vlen (vlen_lat_q),
    .idx  (idx_q),
    .addr (out_vr_addr)
  );

  vec_addr_gen #(
    .DWIDTH_RFADD (DWIDTH_RFADD),
    .ITR_W        (ITR_W)
  ) u_vw_addr (
    .vreg (vw_reg_q),
    .vlen (vlen_lat_q),
    .idx  (idx_q),
    .addr (out_vw_addr)
  );

  assign out_last          = last_q;
  assign out_class         = class_q;
  assign out_op            = op_q;
  assign out_op_scalar     = ops_q;
  assign out_rs1           = rs1_q;
  assign out_rs2           = rs2_q;
  assign out_rd            = rd_q;
  assign out_imm           = imm_q;
  assign out_branch_imm    = bimm_q;
  assign out_wen_rf_scalar = wen_q;
  assign out_elem_idx      = idx_q;
  assign out_mux2_tvalid   = mux2_q;
  assign cfg_vlen          = cfg_vlen_q;
  assign cfg_itr           = cfg_itr_q;
  assign busy              = out_valid && !last_q;

endmodule

// File: tb/tb_vec_decode_issue.sv
// Randomised bench for vec_decode_issue: every accepted instruction is expanded by a
// behavioural model into expected beats, which are compared against the DUT as they issue.
module tb_vec_decode_issue;

  localparam int unsigned W  = 12;
  localparam int unsigned IW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   in_instr;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [3:0]    out_class;
  logic [2:0]    out_op;
  logic [2:0]    out_op_scalar;
  logic [4:0]    out_rs1, out_rs2, out_rd;
  logic [31:0]   out_imm;
  logic [11:0]   out_branch_imm;
  logic          out_wen_rf_scalar;
  logic [W-1:0]  out_vr_addr, out_vw_addr;
  logic [IW-1:0] out_elem_idx;
  logic          out_mux2_tvalid;
  logic [2:0]    cfg_vlen;
  logic [IW-1:0] cfg_itr;
  logic          busy;

  always #5 clk = ~clk;

  vec_decode_issue #(
    .DWIDTH_INST  (32),
    .DWIDTH_RFADD (W),
    .DWIDTH_INT   (32),
    .ITR_W        (IW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_instr          (in_instr),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .out_class         (out_class),
    .out_op            (out_op),
    .out_op_scalar     (out_op_scalar),
    .out_rs1           (out_rs1),
    .out_rs2           (out_rs2),
    .out_rd            (out_rd),
    .out_imm           (out_imm),
    .out_branch_imm    (out_branch_imm),
    .out_wen_rf_scalar (out_wen_rf_scalar),
    .out_vr_addr       (out_vr_addr),
    .out_vw_addr       (out_vw_addr),
    .out_elem_idx      (out_elem_idx),
    .out_mux2_tvalid   (out_mux2_tvalid),
    .cfg_vlen          (cfg_vlen),
    .cfg_itr           (cfg_itr),
    .busy              (busy)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int     cls, op, ops, rs1, rs2, rd, bimm, wen, vr, vw, idx, last, mux2;
    longint imm;
  } beat_t;

  beat_t exp_q[$];
  int    m_vlen = 0;
  int    m_itr  = 0;

  // Class number, or -1 for vsetivli.
  function automatic int classify(input logic [31:0] ins);
    int opc, f3;
    opc = int'(ins[6:0]);
    f3  = int'(ins[14:12]);
    if (opc == 'h57) return (f3 == 0) ? 2 : (f3 == 5) ? 3 : (f3 == 7) ? -1 : 15;
    if (opc == 'h07) return 0;
    if (opc == 'h27) return 1;
    if (opc == 'h7F) return 4;
    if (opc == 'h63 && f3 == 1) return 5;
    if (opc == 'h13 && f3 == 0) return 6;
    if (opc == 'h37) return 7;
    if (opc == 'h33 && f3 == 0 && ins[31:25] == 7'd0) return 8;
    if (opc == 'h03 && int'(ins[31:20]) == 'hC00) return 9;
    return 15;
  endfunction

  function automatic int addr_of(input int r, input int n, input int idx);
    int k, base;
    k    = (n + 1 < 5) ? n + 1 : 5;
    base = (r % (1 << k)) * (1 << (W - 1 - n));
    return (base + idx) % (1 << W);
  endfunction

  function automatic void model_accept(input logic [31:0] ins);
    int    c, nb, vrs, imm12;
    beat_t b;
    c = classify(ins);
    if (c < 0) begin
      m_vlen = int'(ins[17:15]);
      m_itr  = int'(ins[29:18]);
      return;
    end
    nb     = (c <= 4 && m_itr > 1) ? m_itr : 1;
    b.cls  = c;
    b.op   = (c == 2) ? 3 : 4;
    b.ops  = (c == 7) ? 0 : (c == 6) ? 1 : (c == 5) ? 2 : (c == 8) ? 3 : 4;
    b.rs1  = int'(ins[19:15]);
    b.rs2  = int'(ins[24:20]);
    b.rd   = int'(ins[11:7]);
    b.bimm = int'(ins[31]) * 2048 + int'(ins[7]) * 1024 + int'(ins[30:25]) * 16 +
             int'(ins[11:8]);
    b.wen  = (c >= 6 && c <= 9) ? 1 : 0;
    b.mux2 = (c == 2 || c == 4) ? 1 : 0;
    imm12  = int'(ins[31:20]);
    if (c == 6) b.imm = (imm12 >= 2048) ? longint'(imm12) + 64'hFFFF_F000 : longint'(imm12);
    else if (c == 7) b.imm = longint'(ins[31:12]) * 4096;
    else b.imm = 0;
    vrs = (c == 1) ? b.rd : b.rs2;
    for (int i = 0; i < nb; i++) begin
      b.idx  = i;
      b.last = (i == nb - 1) ? 1 : 0;
      b.vr   = addr_of(vrs, m_vlen, i);
      b.vw   = addr_of(b.rd, m_vlen, i);
      exp_q.push_back(b);
    end
  endfunction

  bit chk_en  = 0;
  bit rst_chk = 1;

  always @(negedge clk) begin
    bit    ev, eir;
    beat_t e;
    if (chk_en) begin
      ev  = (exp_q.size() != 0);
      eir = !ev || (out_ready && exp_q[0].last == 1);
      check_eq("out_valid", 64'(out_valid), 64'(ev));
      check_eq("in_ready", 64'(in_ready), 64'(eir));
      check_eq("cfg_vlen", 64'(cfg_vlen), 64'(m_vlen));
      check_eq("cfg_itr", 64'(cfg_itr), 64'(m_itr));
      if (ev && out_valid) begin
        e = exp_q[0];
        check_eq("class", 64'(out_class), 64'(e.cls));
        check_eq("op", 64'(out_op), 64'(e.op));
        check_eq("op_scalar", 64'(out_op_scalar), 64'(e.ops));
        check_eq("rs1", 64'(out_rs1), 64'(e.rs1));
        check_eq("rs2", 64'(out_rs2), 64'(e.rs2));
        check_eq("rd", 64'(out_rd), 64'(e.rd));
        check_eq("imm", 64'(out_imm), 64'(e.imm));
        check_eq("branch_imm", 64'(out_branch_imm), 64'(e.bimm));
        check_eq("wen", 64'(out_wen_rf_scalar), 64'(e.wen));
        check_eq("mux2", 64'(out_mux2_tvalid), 64'(e.mux2));
        check_eq("vr_addr", 64'(out_vr_addr), 64'(e.vr));
        check_eq("vw_addr", 64'(out_vw_addr), 64'(e.vw));
        check_eq("elem_idx", 64'(out_elem_idx), 64'(e.idx));
        check_eq("last", 64'(out_last), 64'(e.last));
        check_eq("busy", 64'(busy), 64'(e.last == 0));
      end
      if (rst_chk) begin
        check_eq("rst_last", 64'(out_last), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_class", 64'(out_class), 64'd0);
        check_eq("rst_op", 64'(out_op), 64'd0);
        check_eq("rst_imm", 64'(out_imm), 64'd0);
        check_eq("rst_vr", 64'(out_vr_addr), 64'd0);
        check_eq("rst_vw", 64'(out_vw_addr), 64'd0);
        check_eq("rst_idx", 64'(out_elem_idx), 64'd0);
        check_eq("rst_wen", 64'(out_wen_rf_scalar), 64'd0);
      end
      if (rst) begin
        exp_q.delete();
        m_vlen  = 0;
        m_itr   = 0;
        rst_chk = 1;
      end else begin
        rst_chk = 0;
        if (ev && out_ready) void'(exp_q.pop_front());
        if (in_valid && eir) model_accept(in_instr);
      end
    end
  end

  // 0: always ready, 1: alternate, 2: random
  int rdy_mode = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] ins);
    bit acc;
    acc      = 0;
    in_valid = 1'b1;
    in_instr = ins;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check_eq("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] mk(input int opc, input int f3, input int rd, input int rs2);
    logic [31:0] r;
    r        = $urandom;
    r[6:0]   = 7'(opc);
    r[14:12] = 3'(f3);
    r[11:7]  = 5'(rd);
    r[24:20] = 5'(rs2);
    return r;
  endfunction

  function automatic logic [31:0] vset(input int vlen, input int itr);
    logic [31:0] r;
    r        = mk('h57, 7, $urandom_range(0, 31), $urandom_range(0, 31));
    r[17:15] = 3'(vlen);
    r[29:18] = 12'(itr);
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          rd, rs2;
    rd  = $urandom_range(0, 31);
    rs2 = $urandom_range(0, 31);
    r   = $urandom;
    case ($urandom_range(0, 13))
      0:  r = mk('h57, 0, rd, rs2);
      1:  r = mk('h57, 5, rd, rs2);
      2:  begin r = mk('h07, 0, rd, rs2); r[14:12] = 3'($urandom); end
      3:  begin r = mk('h27, 0, rd, rs2); r[14:12] = 3'($urandom); end
      4:  r = mk('h7F, $urandom_range(0, 7), rd, rs2);
      5:  r = vset($urandom_range(0, 7), ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 5));
      6:  r = mk('h63, 1, rd, rs2);
      7:  r = mk('h13, 0, rd, rs2);
      8:  r = mk('h37, $urandom_range(0, 7), rd, rs2);
      9:  begin r = mk('h33, 0, rd, rs2); r[31:25] = 7'd0; end
      10: begin r = mk('h03, 2, rd, 0); r[31:20] = 12'hC00; end
      11: begin r = mk('h33, 0, rd, rs2); r[31:25] = 7'd1; end
      12: r = mk('h57, 2, rd, rs2);
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    bit hit;
    in_valid = 1'b0;
    in_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // vlen=2, ITR=4; vmacc vd=3 vs2=5 -> vr 0xA00.., vw 0x600..
    send(vset(2, 4));
    idle(2);
    send(mk('h57, 0, 3, 5));
    idle(6);
    rdy_mode = 1;
    send(mk('h57, 0, 3, 5));
    idle(12);
    rdy_mode = 0;
    send(32'hFFF0_0093);
    send(32'h1234_5137);
    idle(3);
    send(vset(7, 0));
    send(mk('h27, 2, 7, 0));
    idle(3);

    // reset during the second beat of a 4-beat burst
    send(vset(2, 4));
    send(mk('h57, 0, 3, 5));
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      hit = out_valid && (out_elem_idx == '0);
    end
    if (!hit) check_eq("burst_start_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    pulse_rst();
    idle(1);
    send(mk('h57, 0, 9, 4));
    send(32'hFFF0_0093);
    idle(3);

    rdy_mode = 2;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 200) == 0) pulse_rst();
      else if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      else send(rand_instr());
    end

    rdy_mode = 0;
    in_valid = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    idle(2);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
